pc_sequencer: RTL and testbench

Program-counter sequencer for the single-issue datapath: owns the PC register and consumes the 2-bit next-PC select produced by the branch/jump control logic (00 sequential, 01 jump, 10 balz, 11 PC-relative branch). It computes the target, updates the PC, squashes the wrong-path fetch with a one-cycle flush bubble, and writes the link address for balz. It sits between branch/jump control and instruction memory.

---
 rtl/pc_sequencer.sv | 106 ++++++++++
 tb/tb_pc_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, applies jump/balz/branch redirects with a
// one-cycle flush bubble. Optional link write for balz is enabled by defining PC_LINK_EN.
module pc_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [1:0]        i_pc_src,
  input  logic              i_src_valid,
  input  logic [25:0]       i_imm26,
  input  logic [15:0]       i_br_off,
  input  logic              i_stall,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus4,
  output logic              o_flush,
  output logic              o_link_we,
  output logic [ADDR_W-1:0] o_link_data,
  output logic              o_busy,
  output logic              o_dbg_state
);

  // Handshake: there is no ready/valid pair. i_src_valid qualifies the select
  // fields for the instruction at o_pc; i_stall freezes RUN and the producer
  // must hold the select fields stable until i_stall drops.

  typedef enum logic {S_RUN = 1'b0, S_FLUSH = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_jump_tgt;
  logic [ADDR_W-1:0] w_br_tgt;
  logic              w_taken;

  assign w_pc_plus4 = r_pc + PC_STEP;
  assign w_jump_tgt = {w_pc_plus4[31:28], i_imm26, 2'b00};
  assign w_br_tgt   = w_pc_plus4 + {{14{i_br_off[15]}}, i_br_off, 2'b00};
  assign w_taken    = i_src_valid && (i_pc_src != 2'b00);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      S_RUN: begin
        if (!i_stall) begin
          if (w_taken) begin
            w_state_nxt = S_FLUSH;
            w_pc_nxt    = (i_pc_src == 2'b11) ? w_br_tgt : w_jump_tgt;
          end else begin
            w_pc_nxt = w_pc_plus4;
          end
        end
      end
      // PC holds the target through the bubble; exit is unconditional.
      S_FLUSH: w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

`ifdef PC_LINK_EN
  logic              w_balz_fire;
  logic              r_link_we;
  logic [ADDR_W-1:0] r_link_data;

  assign w_balz_fire = (r_state == S_RUN) && !i_stall && i_src_valid && (i_pc_src == 2'b10);

  // Return address skips the squashed slot, hence pc + 8.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_link_we   <= 1'b0;
      r_link_data <= '0;
    end else begin
      r_link_we <= w_balz_fire;
      if (w_balz_fire) r_link_data <= w_pc_plus4 + PC_STEP;
    end
  end

  assign o_link_we   = r_link_we;
  assign o_link_data = r_link_data;
`else
  assign o_link_we   = 1'b0;
  assign o_link_data = '0;
`endif

  assign o_pc        = r_pc;
  assign o_pc_plus4  = w_pc_plus4;
  assign o_flush     = (r_state == S_FLUSH);
  assign o_busy      = (r_state == S_FLUSH);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer: driver pushes hand-computed expectations,
// a negedge monitor pops and compares them against the selected DUT instance.
module tb_pc_sequencer;

  localparam int EXP_W = 68;  // {sel, pc[31:0], flush, busy, link_we, link_data[31:0]}
`ifdef PC_LINK_EN
  localparam bit LINK_ON = 1'b1;
`else
  localparam bit LINK_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [1:0]  pc_src;
  logic        src_valid;
  logic [25:0] imm26;
  logic [15:0] br_off;
  logic        stall;

  logic [31:0] lo_pc, lo_pc4, lo_ldata, hi_pc, hi_pc4, hi_ldata;
  logic        lo_flush, lo_lwe, lo_busy, lo_st, hi_flush, hi_lwe, hi_busy, hi_st;

  logic [EXP_W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int vec_n = 0;

  pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_0100)) u_dut_lo (
    .i_clk(clk), .i_reset(reset), .i_pc_src(pc_src), .i_src_valid(src_valid),
    .i_imm26(imm26), .i_br_off(br_off), .i_stall(stall),
    .o_pc(lo_pc), .o_pc_plus4(lo_pc4), .o_flush(lo_flush), .o_link_we(lo_lwe),
    .o_link_data(lo_ldata), .o_busy(lo_busy), .o_dbg_state(lo_st)
  );

  // Second instance exercises the upper PC nibble carried into jump targets.
  pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h4000_0010)) u_dut_hi (
    .i_clk(clk), .i_reset(reset), .i_pc_src(pc_src), .i_src_valid(src_valid),
    .i_imm26(imm26), .i_br_off(br_off), .i_stall(stall),
    .o_pc(hi_pc), .o_pc_plus4(hi_pc4), .o_flush(hi_flush), .o_link_we(hi_lwe),
    .o_link_data(hi_ldata), .o_busy(hi_busy), .o_dbg_state(hi_st)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL vec%0d %s: got=%h expected=%h", vec_n, name, act, exp);
    end
  endtask

  // Driver: apply one cycle of stimulus, then queue the state expected after the edge.
  task automatic vec(input logic sel, input logic rst, input logic stl, input logic vld,
                     input logic [1:0] src, input logic [25:0] imm, input logic [15:0] off,
                     input logic [31:0] e_pc, input logic e_fl,
                     input logic e_lwe, input logic [31:0] e_ldata);
    @(negedge clk);
    #1;
    reset = rst; stall = stl; src_valid = vld; pc_src = src; imm26 = imm; br_off = off;
    @(posedge clk);
    exp_q.push_back({sel, e_pc, e_fl, e_fl, e_lwe, e_ldata});
  endtask

  task automatic idle(input logic sel, input logic [31:0] e_pc, input logic e_fl,
                      input logic [31:0] e_ldata);
    vec(sel, 1'b0, 1'b0, 1'b0, 2'b00, 26'h0, 16'h0, e_pc, e_fl, 1'b0, e_ldata);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EXP_W-1:0] e;
      logic [31:0] a_pc, a_pc4, a_ld;
      logic        a_fl, a_bz, a_we;
      e = exp_q.pop_front();
      vec_n++;
      if (e[67]) begin
        a_pc = hi_pc; a_pc4 = hi_pc4; a_fl = hi_flush; a_bz = hi_busy; a_we = hi_lwe; a_ld = hi_ldata;
      end else begin
        a_pc = lo_pc; a_pc4 = lo_pc4; a_fl = lo_flush; a_bz = lo_busy; a_we = lo_lwe; a_ld = lo_ldata;
      end
      chk("pc",        a_pc,         e[66:35]);
      chk("pc_plus4",  a_pc4,        e[66:35] + 32'd4);
      chk("flush",     {31'b0, a_fl}, {31'b0, e[34]});
      chk("busy",      {31'b0, a_bz}, {31'b0, e[33]});
      chk("link_we",   {31'b0, a_we}, {31'b0, e[32]});
      chk("link_data", a_ld,         e[31:0]);
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; src_valid = 1'b0; pc_src = 2'b00; imm26 = '0; br_off = '0;

    // High-region instance: reset, jump keeps pc_plus4[31:28]
    vec(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 26'h0, 16'h0, 32'h4000_0010, 1'b0, 1'b0, 32'h0);
    vec(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 26'h000_0040, 16'h0, 32'h4000_0100, 1'b1, 1'b0, 32'h0);
    idle(1'b1, 32'h4000_0100, 1'b0, 32'h0);
    idle(1'b1, 32'h4000_0104, 1'b0, 32'h0);

    // Reset and sequential advance
    vec(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 26'h0, 16'h0, 32'h0000_0100, 1'b0, 1'b0, 32'h0);
    idle(1'b0, 32'h0000_0104, 1'b0, 32'h0);
    idle(1'b0, 32'h0000_0108, 1'b0, 32'h0);
    idle(1'b0, 32'h0000_010C, 1'b0, 32'h0);

    // Jump to 0x1000, then backward branch by -2 words
    vec(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 26'h000_0400, 16'h0, 32'h0000_1000, 1'b1, 1'b0, 32'h0);
    idle(1'b0, 32'h0000_1000, 1'b0, 32'h0);
    vec(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 26'h0, 16'hFFFE, 32'h0000_0FFC, 1'b1, 1'b0, 32'h0);
    idle(1'b0, 32'h0000_0FFC, 1'b0, 32'h0);
    idle(1'b0, 32'h0000_1000, 1'b0, 32'h0);

    // Stall holds a pending branch, then it redirects; stall during FLUSH does not block exit
    for (int i = 0; i < 3; i++)
      vec(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 26'h0, 16'h0010, 32'h0000_1000, 1'b0, 1'b0, 32'h0);
    vec(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 26'h0, 16'h0010, 32'h0000_1044, 1'b1, 1'b0, 32'h0);
    vec(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 26'h0, 16'h0, 32'h0000_1044, 1'b0, 1'b0, 32'h0);
    vec(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 26'h0, 16'h0, 32'h0000_1044, 1'b0, 1'b0, 32'h0);
    idle(1'b0, 32'h0000_1048, 1'b0, 32'h0);

    // balz at 0x200: link strobe one cycle, link_data held afterwards
    vec(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 26'h000_0080, 16'h0, 32'h0000_0200, 1'b1, 1'b0, 32'h0);
    idle(1'b0, 32'h0000_0200, 1'b0, 32'h0);
    vec(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 26'h000_0080, 16'h0, 32'h0000_0200, 1'b1,
        LINK_ON, LINK_ON ? 32'h0000_0208 : 32'h0);
    idle(1'b0, 32'h0000_0200, 1'b0, LINK_ON ? 32'h0000_0208 : 32'h0);
    idle(1'b0, 32'h0000_0204, 1'b0, LINK_ON ? 32'h0000_0208 : 32'h0);
    // src_valid low: select ignored
    vec(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 26'h0, 16'h0040, 32'h0000_0208, 1'b0, 1'b0,
        LINK_ON ? 32'h0000_0208 : 32'h0);

    // Reset during FLUSH wins over a pending select
    vec(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 26'h0, 16'h0004, 32'h0000_021C, 1'b1, 1'b0,
        LINK_ON ? 32'h0000_0208 : 32'h0);
    vec(1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 26'h0, 16'h0004, 32'h0000_0100, 1'b0, 1'b0, 32'h0);

    // Branch wraps below zero, sequential wraps past 0xFFFF_FFFC
    vec(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 26'h0, 16'hFFBE, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);
    idle(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0);
    idle(1'b0, 32'h0000_0000, 1'b0, 32'h0);
    idle(1'b0, 32'h0000_0004, 1'b0, 32'h0);

    // Drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
